// File: rtl/sync_ram_fifo_ctrl.sv
// ---------------------------------------------------------------------------
// sync_ram_fifo_ctrl
//   Turns a single-port synchronous RAM (one write or one read per clock,
//   read data valid the cycle after the read is issued) into a FIFO. Pushed
//   words are written to RAM; the head word is prefetched into a registered
//   output stage and presented on a valid/ready pop interface.
//
// Optional feature (macro RAM_FIFO_FLUSH_EN):
//   defined   -> adds a synchronous active-high 'flush' input that empties the
//                FIFO at the next rising edge (out_data is kept).
//   undefined -> no flush port; contents are cleared only by rst_n.
//
// Ports
//   clk, rst_n           clock, asynchronous active-low reset
//   flush                (RAM_FIFO_FLUSH_EN only) synchronous clear
//   in_valid/in_ready    push handshake, in_data is the pushed word
//   out_valid/out_ready  pop handshake, out_data is the registered head word
//   level                words held: RAM + in-flight read + output register
//   ram_we/addr/din      combinational drive to the RAM
//   ram_dout             RAM read data
// ---------------------------------------------------------------------------
module sync_ram_fifo_ctrl #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
`ifdef RAM_FIFO_FLUSH_EN
  input  logic              flush,
`endif
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W:0]   level,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_din,
  input  logic [DATA_W-1:0] ram_dout
);

  localparam int              DEPTH     = 2 ** ADDR_W;
  localparam logic [ADDR_W:0]   DEPTH_CNT = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0]   ZERO_CNT  = {(ADDR_W + 1){1'b0}};
  localparam logic [ADDR_W:0]   ONE_CNT   = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] ZERO_PTR  = {ADDR_W{1'b0}};
  localparam logic [ADDR_W-1:0] ONE_PTR   = {{(ADDR_W - 1){1'b0}}, 1'b1};
  localparam logic [DATA_W-1:0] ZERO_DATA = {DATA_W{1'b0}};

  // IDLE: output stage empty, FETCH: read in flight, HOLD: out_data valid
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_HOLD  = 2'd2
  } state_t;

  state_t              state_r;
  logic [ADDR_W-1:0]   wr_ptr_r;
  logic [ADDR_W-1:0]   rd_ptr_r;
  logic [ADDR_W:0]     mem_cnt_r;
  logic                rd_pend_r;
  logic                out_valid_r;
  logic [DATA_W-1:0]   out_data_r;
  logic [ADDR_W:0]     level_r;

  logic                flush_s;
  logic                rd_issue_s;
  logic                in_ready_s;
  logic                wr_s;
  logic                pop_s;
  logic [ADDR_W:0]     mem_cnt_nxt_s;
  logic                rd_pend_nxt_s;
  logic                out_valid_nxt_s;
  logic [ADDR_W:0]     level_nxt_s;

`ifdef RAM_FIFO_FLUSH_EN
  assign flush_s = flush;
`else
  assign flush_s = 1'b0;
`endif

  // Handshake and arbitration: a pending prefetch read beats a push, and a
  // flush cycle neither reads nor writes. in_ready is also low in reset.
  always_comb begin
    rd_issue_s = (mem_cnt_r != ZERO_CNT) && !rd_pend_r && !out_valid_r && !flush_s;
    in_ready_s = rst_n && !flush_s && (mem_cnt_r != DEPTH_CNT) && !rd_issue_s;
    wr_s       = in_valid && in_ready_s;
    pop_s      = out_valid_r && out_ready;
  end

  // Next-state values for the counters so that level can be registered
  // consistently with them.
  always_comb begin
    mem_cnt_nxt_s   = mem_cnt_r;
    out_valid_nxt_s = out_valid_r;
    rd_pend_nxt_s   = rd_issue_s;
    if (flush_s) begin
      mem_cnt_nxt_s = ZERO_CNT;
    end else if (wr_s) begin
      mem_cnt_nxt_s = mem_cnt_r + ONE_CNT;
    end else if (rd_issue_s) begin
      mem_cnt_nxt_s = mem_cnt_r - ONE_CNT;
    end else begin
      mem_cnt_nxt_s = mem_cnt_r;
    end
    if (flush_s) begin
      out_valid_nxt_s = 1'b0;
    end else if (rd_pend_r) begin
      out_valid_nxt_s = 1'b1;
    end else if (pop_s) begin
      out_valid_nxt_s = 1'b0;
    end else begin
      out_valid_nxt_s = out_valid_r;
    end
    level_nxt_s = mem_cnt_nxt_s
                + {{ADDR_W{1'b0}}, rd_pend_nxt_s}
                + {{ADDR_W{1'b0}}, out_valid_nxt_s};
  end

  // Controller state: pointers, occupancy, output-stage FSM and out_data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      wr_ptr_r    <= ZERO_PTR;
      rd_ptr_r    <= ZERO_PTR;
      mem_cnt_r   <= ZERO_CNT;
      rd_pend_r   <= 1'b0;
      out_valid_r <= 1'b0;
      out_data_r  <= ZERO_DATA;
      level_r     <= ZERO_CNT;
    end else begin
      mem_cnt_r   <= mem_cnt_nxt_s;
      rd_pend_r   <= rd_pend_nxt_s;
      out_valid_r <= out_valid_nxt_s;
      level_r     <= level_nxt_s;
      if (flush_s) begin
        state_r  <= ST_IDLE;
        wr_ptr_r <= ZERO_PTR;
        rd_ptr_r <= ZERO_PTR;
      end else begin
        // pointers wrap naturally at DEPTH; full/empty come from mem_cnt
        if (wr_s) begin
          wr_ptr_r <= wr_ptr_r + ONE_PTR;
        end else begin
          wr_ptr_r <= wr_ptr_r;
        end
        if (rd_issue_s) begin
          rd_ptr_r <= rd_ptr_r + ONE_PTR;
        end else begin
          rd_ptr_r <= rd_ptr_r;
        end
        case (state_r)
          ST_IDLE: begin
            state_r <= rd_issue_s ? ST_FETCH : ST_IDLE;
          end
          ST_FETCH: begin
            // RAM data for the read issued last cycle is on ram_dout now
            state_r    <= ST_HOLD;
            out_data_r <= ram_dout;
          end
          ST_HOLD: begin
            state_r <= pop_s ? ST_IDLE : ST_HOLD;
          end
          default: begin
            state_r <= ST_IDLE;
          end
        endcase
      end
    end
  end

  assign in_ready  = in_ready_s;
  assign ram_we    = wr_s;
  assign ram_addr  = wr_s ? wr_ptr_r : rd_ptr_r;
  assign ram_din   = in_data;
  assign out_valid = out_valid_r;
  assign out_data  = out_data_r;
  assign level     = level_r;

endmodule

// File: tb/tb_sync_ram_fifo_ctrl.sv
// Bench for sync_ram_fifo_ctrl: a behavioural RAM, a word-queue model of the
// FIFO with a three-phase output stage (issue, in flight, presented), one
// per-cycle compare process, and directed scenarios with literal checks.
module tb_sync_ram_fifo_ctrl;

  logic       clk;
  logic       rst_n;
  logic       flush;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic [4:0] level;
  logic       ram_we;
  logic [3:0] ram_addr;
  logic [7:0] ram_din;
  logic [7:0] ram_dout;

  int checks = 0;
  int errors = 0;

  sync_ram_fifo_ctrl #(.DATA_W(8), .ADDR_W(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
`ifdef RAM_FIFO_FLUSH_EN
    .flush    (flush),
`endif
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .level    (level),
    .ram_we   (ram_we),
    .ram_addr (ram_addr),
    .ram_din  (ram_din),
    .ram_dout (ram_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // 16x8 single-port synchronous RAM, registered read data
  logic [7:0] mem [16];
  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 8'h00;
    ram_dout = 8'h00;
  end
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_din;
    ram_dout <= mem[ram_addr];
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [7:0] q[$];        // every word held, oldest first
  int         n_ram;       // words still sitting in RAM
  int         stage;       // 0 empty, 1 read in flight, 2 head presented
  int         wr_cnt;      // words written since last clear
  int         rd_cnt;      // reads issued since last clear
  int         pop_count = 0;
  logic [7:0] exp_od;

  always @(negedge clk) begin : model_cmp
    logic       issue_m, ir_m, we_m, pop_m;
    logic [3:0] addr_m;
    if (!rst_n) begin
      q.delete();
      n_ram  = 0;
      stage  = 0;
      wr_cnt = 0;
      rd_cnt = 0;
      exp_od = 8'h00;
    end
    issue_m = rst_n && !flush && (n_ram > 0) && (stage == 0);
    ir_m    = rst_n && !flush && (n_ram < 16) && !issue_m;
    we_m    = in_valid && ir_m;
    addr_m  = we_m ? 4'(wr_cnt % 16) : 4'(rd_cnt % 16);
    pop_m   = (stage == 2) && out_ready;
    chk("m_in_ready", 32'(in_ready), 32'(ir_m));
    chk("m_ram_we", 32'(ram_we), 32'(we_m));
    chk("m_ram_addr", 32'(ram_addr), 32'(addr_m));
    chk("m_out_valid", 32'(out_valid), 32'(stage == 2));
    chk("m_level", 32'(level), 32'(q.size()));
    chk("m_out_data", 32'(out_data), 32'(exp_od));
    if (we_m) chk("m_ram_din", 32'(ram_din), 32'(in_data));
    if (rst_n) begin
      if (flush) begin
        q.delete();
        n_ram  = 0;
        stage  = 0;
        wr_cnt = 0;
        rd_cnt = 0;
      end else begin
        if (we_m) begin
          q.push_back(in_data);
          n_ram++;
          wr_cnt++;
        end
        if (issue_m) begin
          n_ram--;
          rd_cnt++;
          stage = 1;
        end else if (stage == 1) begin
          stage  = 2;
          exp_od = q[0];
        end else if (pop_m) begin
          void'(q.pop_front());
          pop_count++;
          stage = 0;
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic push(input logic [7:0] d);
    bit acc = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b1;
    in_data  = d;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (in_ready) begin
        acc = 1'b1;
        break;
      end
    end
    chk("push_accepted", 32'(acc), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    bit done = 1'b0;
    @(posedge clk); #1;
    out_ready = 1'b1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (level == 5'd0) begin
        done = 1'b1;
        break;
      end
    end
    chk("drain_done", 32'(done), 32'd1);
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int sent;
    int pops0;
    int cyc;
    rst_n     = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b1;
    in_data   = 8'hA5;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);

    // reset state with a push request pending
    @(negedge clk);
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_ram_we", 32'(ram_we), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'h00);

    // single word 0xA5
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    chk("sw_in_ready", 32'(in_ready), 32'd1);
    chk("sw_we", 32'(ram_we), 32'd1);
    chk("sw_waddr", 32'(ram_addr), 32'd0);
    @(posedge clk); #1 in_valid = 1'b0;
    @(negedge clk);
    chk("sw_issue_ready", 32'(in_ready), 32'd0);
    chk("sw_raddr", 32'(ram_addr), 32'd0);
    @(posedge clk);
    @(negedge clk);
    chk("sw_pend_ov", 32'(out_valid), 32'd0);
    chk("sw_pend_level", 32'(level), 32'd1);
    @(posedge clk); #1 out_ready = 1'b1;
    @(negedge clk);
    chk("sw_ov", 32'(out_valid), 32'd1);
    chk("sw_data", 32'(out_data), 32'hA5);
    chk("sw_level", 32'(level), 32'd1);
    @(posedge clk); #1 out_ready = 1'b0;
    @(negedge clk);
    chk("sw_pop_ov", 32'(out_valid), 32'd0);
    chk("sw_pop_level", 32'(level), 32'd0);
    chk("sw_hold_data", 32'(out_data), 32'hA5);

    // collision: push lands, next cycle a read pre-empts the next push
    @(posedge clk); #1;
    in_valid = 1'b1;
    in_data  = 8'h11;
    @(negedge clk);
    chk("col_first_addr", 32'(ram_addr), 32'd1);
    @(posedge clk); #1 in_data = 8'h22;
    @(negedge clk);
    chk("col_in_ready", 32'(in_ready), 32'd0);
    chk("col_we", 32'(ram_we), 32'd0);
    chk("col_raddr", 32'(ram_addr), 32'd1);
    @(posedge clk);
    @(negedge clk);
    chk("col_retry_ready", 32'(in_ready), 32'd1);
    chk("col_retry_addr", 32'(ram_addr), 32'd2);
    @(posedge clk); #1 in_valid = 1'b0;
    drain();

    // fill: 17 words fit (16 in RAM + output register)
    for (int i = 0; i < 17; i++) push(8'(i));
    repeat (3) @(posedge clk);
    #1;
    in_valid = 1'b1;
    in_data  = 8'h11;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("full_in_ready", 32'(in_ready), 32'd0);
      chk("full_we", 32'(ram_we), 32'd0);
      chk("full_level", 32'(level), 32'd17);
      @(posedge clk);
    end
    #1 in_valid = 1'b0;
    @(negedge clk);
    chk("full_head", 32'(out_data), 32'h00);
    drain();

    // random valid/ready traffic across pointer wrap
    sent  = 0;
    pops0 = pop_count;
    cyc   = 0;
    while ((sent < 40 || level != 5'd0) && cyc < 3000) begin
      @(posedge clk); #1;
      in_valid  = (sent < 40) && ($urandom_range(0, 1) == 1);
      in_data   = 8'h40 + 8'(sent);
      out_ready = ($urandom_range(0, 1) == 1);
      @(negedge clk);
      if (in_valid && in_ready) sent++;
      cyc++;
    end
    @(posedge clk); #1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    chk("rand_sent", 32'(sent), 32'd40);
    chk("rand_popped", 32'(pop_count - pops0), 32'd40);

    // reset in the middle of traffic
    push(8'h71);
    push(8'h72);
    push(8'h73);
    @(posedge clk); #1;
    rst_n    = 1'b0;
    in_valid = 1'b1;
    in_data  = 8'h5A;
    @(negedge clk);
    chk("mrst_ov", 32'(out_valid), 32'd0);
    chk("mrst_level", 32'(level), 32'd0);
    chk("mrst_in_ready", 32'(in_ready), 32'd0);
    chk("mrst_we", 32'(ram_we), 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    chk("mrst_release_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1 in_valid = 1'b0;
    drain();

`ifdef RAM_FIFO_FLUSH_EN
    for (int i = 0; i < 5; i++) push(8'h90 + 8'(i));
    repeat (4) @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk); #1 flush = 1'b0;
    @(negedge clk);
    chk("flush_level", 32'(level), 32'd0);
    chk("flush_ov", 32'(out_valid), 32'd0);
    push(8'h3C);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("flush_next_ov", 32'(out_valid), 32'd1);
    chk("flush_next_data", 32'(out_data), 32'h3C);
    drain();
`endif

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
